sc_mips: RTL and testbench
==========================

# sc_mips

Fixed-function UART GCD engine used as the top-level demo block of the board design. It receives two 8-bit operands as 8N1 UART bytes, computes their greatest common divisor with an iterative subtract datapath, and transmits the result as one UART byte. The result and the last received byte are shown on LEDs and four 7-segment digits.

## Interface
- CLKS_PER_BIT, default 48: `sysclk` cycles per UART bit, used for both RX and TX. At the 2-cycle-period bench clock this gives a 96-time-unit bit.
- `sysclk`, input, 1: the single clock; everything is on its rising edge.
- `Reset_n`, input, 1: one clock; reset is synchronous and active-high. The port keeps the codebase name `Reset_n`, but reset is asserted when it is 1.
- `switch`, input, 8: bit 0 is the LED select; bits 7:1 are ignored.
- `UART_IN`, input, 1: RX serial line, 8N1, LSB first, idle high. Pass it through a 2-flop synchronizer.
- `UART_OUT`, output, 1: TX serial line, 8N1, LSB first, idle high.
- `led`, output, 8:
  - `switch[0]=0`: shows the result register.
  - `switch[0]=1`: shows operand A.
- `digi_out1`..`digi_out4`, output, 7 each: active-low segments, bit order {g,f,e,d,c,b,a}.
  - `digi_out1` / `digi_out2`: result low / high nibble.
  - `digi_out3` / `digi_out4`: last accepted RX byte, low / high nibble.

## Operation
- **RX**
  - Waits for a high-to-low edge on the synchronized line.
  - Re-samples at CLKS_PER_BIT/2 to confirm the start bit; a start bit sampled high is a glitch, so return to idle.
  - Samples 8 data bits, then the stop bit, each at bit centre (every CLKS_PER_BIT).
  - Stop bit 1: pulse `rx_valid` for one cycle with the byte.
  - Stop bit 0 (framing error): discard the byte, then wait for the line to be high before re-arming.
- **Control FSM**, states WAIT_A → WAIT_B → CALC → SEND → WAIT_A.
  - WAIT_A: on `rx_valid`, A←byte, go to WAIT_B.
  - WAIT_B: on `rx_valid`, B←byte, load the working regs x←A, y←B, go to CALC.
  - CALC: one step per cycle:
    - x==0 → result←y, go to SEND.
    - y==0 → result←x, go to SEND.
    - x==y → result←x, go to SEND.
    - x>y → x←x−y.
    - otherwise → y←y−x.
    - So gcd(0,0)=0 and gcd(0,n)=n.
  - SEND: start TX of result; return to WAIT_A when TX reports done.
  - `rx_valid` in CALC or SEND is dropped; RX itself keeps running.
- **TX**: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles, then the line returns idle.
- **Display**
  - The result register holds its value until the next CALC completes.
  - The digit 3/4 register updates on every accepted byte, A or B.
  - Hex-to-7-seg table, active low:
    - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000
    - 4: 0011001, 5: 0010010, 6: 0000010, 7: 1111000
    - 8: 0000000, 9: 0010000, A: 0001000, b: 0000011
    - C: 1000110, d: 0100001, E: 0000110, F: 0001110
- All arithmetic is 8-bit unsigned. Subtraction never underflows because the larger value is always the one reduced.

## Timing
- Reset, while `Reset_n`=1 at a clock edge:
  - FSM goes to WAIT_A; RX and TX go idle.
  - `UART_OUT`=1.
  - A, B and result are 0, so `led`=0 (either switch setting).
  - All four digits show 1000000.
- Reset mid-frame or mid-CALC aborts everything; it takes effect on the next edge.
- RX latency: `rx_valid` is asserted in the cycle after the stop-bit centre sample.
- CALC takes k+1 cycles, where k is the number of subtractions. The final cycle detects the terminating condition.
- The TX start bit (`UART_OUT`=0) begins on the cycle after leaving CALC.
- A full TX frame is 10×CLKS_PER_BIT cycles. Back in WAIT_A the FSM can accept a new byte immediately.
- `led` and the digits are combinational decodes of registers, so they update the cycle after the register loads.

## Test plan
- **Reset**: hold `Reset_n`=1 for 3 cycles → `UART_OUT`=1, `led`=0x00, all `digi_out`=1000000.
- **Nominal GCD**: send 0x0C then 0x08 at 48 cycles/bit, bytes back to back. Required response:
  - CALC lasts 3 cycles.
  - `UART_OUT` frame carries 0x04.
  - `led`=0x04 with `switch`=0.
  - `digi_out1`=0011001, `digi_out2`=1000000.
  - `digi_out3`=0000000 (8), `digi_out4`=1000000.
- **Operand A display**: after the nominal test, set `switch`=0x01 → `led`=0x0C.
- **Zero operands**:
  - Send 0x00, 0x2D → result 0x2D on `led` and TX.
  - Send 0x00, 0x00 → result 0x00.
- **Framing error**: send a byte whose stop bit is 0, then 0x06, 0x09 → the bad byte is ignored and the result is 0x03.
- **Reset mid-operation**: assert reset during B's data bits, release, then send 0xFF, 0x11 → result 0x11. No TX frame is emitted before that.

Source files
------------

// File: rtl/sc_mips.sv
// sc_mips - UART GCD demo engine.
//
// Receives two 8-bit operands as 8N1 UART bytes, computes their greatest
// common divisor with an iterative subtract datapath and transmits the result
// as one UART byte. The result and the last accepted byte drive the LEDs and
// four active-low 7-segment digits.
//
// Ports:
//   sysclk     in   1  single clock, rising edge
//   Reset_n    in   1  synchronous reset, asserted HIGH despite the name
//   switch     in   8  bit 0 selects LED source (0: result, 1: operand A)
//   UART_IN    in   1  RX serial line, 8N1, LSB first, idle high
//   UART_OUT   out  1  TX serial line, 8N1, LSB first, idle high
//   led        out  8  result or operand A
//   digi_out1  out  7  result low nibble        {g,f,e,d,c,b,a}, active low
//   digi_out2  out  7  result high nibble
//   digi_out3  out  7  last accepted byte, low nibble
//   digi_out4  out  7  last accepted byte, high nibble
module sc_mips #(
  parameter int CLKS_PER_BIT = 48
) (
  input  logic       sysclk,
  input  logic       Reset_n,
  input  logic [7:0] switch,
  input  logic       UART_IN,
  output logic       UART_OUT,
  output logic [7:0] led,
  output logic [6:0] digi_out1,
  output logic [6:0] digi_out2,
  output logic [6:0] digi_out3,
  output logic [6:0] digi_out4
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // The codebase keeps the name Reset_n, but the reset is active high.
  logic srst;
  assign srst = Reset_n;

  // Only switch[0] is used.
  logic unused_switch;
  assign unused_switch = ^switch[7:1];

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_HOLD} rx_state_t;

  rx_state_t        rx_state_reg;
  logic             rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [CNT_W-1:0] rx_cnt_reg;
  logic [2:0]       rx_bit_reg;
  logic [7:0]       rx_shift_reg;
  logic [7:0]       rx_data_reg;
  logic             rx_valid_reg;

  always_ff @(posedge sysclk) begin
    if (srst) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_meta_reg  <= UART_IN;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      rx_valid_reg <= 1'b0;
      unique case (rx_state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_sync_reg) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            // Start bit gone high again by its centre: treat as a glitch.
            rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
            if (rx_bit_reg == 3'd7) begin
              rx_state_reg <= RX_STOP;
            end else begin
              rx_bit_reg <= rx_bit_reg + 3'd1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg <= '0;
            if (rx_sync_reg) begin
              rx_valid_reg <= 1'b1;
              rx_data_reg  <= rx_shift_reg;
              rx_state_reg <= RX_IDLE;
            end else begin
              // Framing error: drop the byte and wait for an idle line.
              rx_state_reg <= RX_HOLD;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
          end
        end
        RX_HOLD: begin
          if (rx_sync_reg) rx_state_reg <= RX_IDLE;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and GCD datapath
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {WAIT_A, WAIT_B, CALC, SEND} state_t;

  state_t     state_reg;
  logic [7:0] a_reg;
  logic [7:0] x_reg, y_reg;
  logic [7:0] result_reg;
  logic [7:0] shown_reg;    // last accepted RX byte, for digits 3/4
  logic       calc_done;
  logic [7:0] calc_value;
  logic       tx_done_reg;

  // Terminating condition of the subtract loop; x==0 yields y, every other
  // terminating case yields x (gcd(0,0) = 0 falls out naturally).
  assign calc_done  = (state_reg == CALC) &&
                      ((x_reg == 8'd0) || (y_reg == 8'd0) || (x_reg == y_reg));
  assign calc_value = (x_reg == 8'd0) ? y_reg : x_reg;

  always_ff @(posedge sysclk) begin
    if (srst) begin
      state_reg  <= WAIT_A;
      a_reg      <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      result_reg <= '0;
      shown_reg  <= '0;
    end else begin
      unique case (state_reg)
        WAIT_A: begin
          if (rx_valid_reg) begin
            a_reg     <= rx_data_reg;
            shown_reg <= rx_data_reg;
            state_reg <= WAIT_B;
          end
        end
        WAIT_B: begin
          // Operand B goes straight into the working register y.
          if (rx_valid_reg) begin
            shown_reg <= rx_data_reg;
            x_reg     <= a_reg;
            y_reg     <= rx_data_reg;
            state_reg <= CALC;
          end
        end
        CALC: begin
          if (calc_done) begin
            result_reg <= calc_value;
            state_reg  <= SEND;
          end else if (x_reg > y_reg) begin
            x_reg <= x_reg - y_reg;
          end else begin
            y_reg <= y_reg - x_reg;
          end
        end
        SEND: begin
          if (tx_done_reg) state_reg <= WAIT_A;
        end
        default: state_reg <= WAIT_A;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // UART transmitter
  // ---------------------------------------------------------------------------
  // The frame is loaded on the same edge that CALC terminates, so the start
  // bit appears in the first SEND cycle. The shift register refills with ones,
  // which leaves the line idle high once all ten bits are out.
  logic [9:0]       tx_shift_reg;
  logic [CNT_W-1:0] tx_cnt_reg;
  logic [3:0]       tx_bit_reg;
  logic             tx_busy_reg;

  always_ff @(posedge sysclk) begin
    if (srst) begin
      tx_shift_reg <= '1;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_busy_reg  <= 1'b0;
      tx_done_reg  <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      if (calc_done && !tx_busy_reg) begin
        tx_shift_reg <= {1'b1, calc_value, 1'b0};
        tx_cnt_reg   <= '0;
        tx_bit_reg   <= '0;
        tx_busy_reg  <= 1'b1;
      end else if (tx_busy_reg) begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_reg   <= '0;
          tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
          if (tx_bit_reg == 4'd9) begin
            tx_busy_reg <= 1'b0;
            tx_done_reg <= 1'b1;
          end else begin
            tx_bit_reg <= tx_bit_reg + 4'd1;
          end
        end else begin
          tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
        end
      end
    end
  end

  assign UART_OUT = tx_shift_reg[0];

  // ---------------------------------------------------------------------------
  // Display decode
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [3:0] nibble [4];
  logic [6:0] seg    [4];

  assign nibble[0] = result_reg[3:0];
  assign nibble[1] = result_reg[7:4];
  assign nibble[2] = shown_reg[3:0];
  assign nibble[3] = shown_reg[7:4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_seg
      assign seg[gi] = hex_to_seg(nibble[gi]);
    end
  endgenerate

  assign digi_out1 = seg[0];
  assign digi_out2 = seg[1];
  assign digi_out3 = seg[2];
  assign digi_out4 = seg[3];

  assign led = switch[0] ? a_reg : result_reg;

endmodule

// File: tb/tb_sc_mips.sv
// tb_sc_mips - directed bench for the UART GCD engine sc_mips.
// Drives UART bytes into UART_IN, decodes frames on UART_OUT in a separate
// monitor process and checks results, LEDs, digits and CALC duration.
module tb_sc_mips;

  localparam int CPB = 48;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_D = 7'b0100001;

  logic       sysclk = 1'b0;
  logic       Reset_n;
  logic [7:0] switch;
  logic       UART_IN;
  logic       UART_OUT;
  logic [7:0] led;
  logic [6:0] digi_out1, digi_out2, digi_out3, digi_out4;

  sc_mips #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk   (sysclk),
    .Reset_n  (Reset_n),
    .switch   (switch),
    .UART_IN  (UART_IN),
    .UART_OUT (UART_OUT),
    .led      (led),
    .digi_out1(digi_out1),
    .digi_out2(digi_out2),
    .digi_out3(digi_out3),
    .digi_out4(digi_out4)
  );

  always #1 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- TX frame monitor ----------------
  logic [7:0] frames [$];
  int         falls  [$];
  bit         oks    [$];
  bit         mon_en = 1'b0;

  initial begin
    logic [7:0] d;
    int         f;
    bit         ok;
    forever begin
      @(negedge sysclk);
      if (mon_en && UART_OUT === 1'b0) begin
        f = cyc;
        repeat (CPB / 2) @(negedge sysclk);
        ok = (UART_OUT === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge sysclk);
          d[i] = UART_OUT;
        end
        repeat (CPB) @(negedge sysclk);
        ok = ok && (UART_OUT === 1'b1);
        frames.push_back(d);
        falls.push_back(f);
        oks.push_back(ok);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int frame_idx = 0;

  task automatic send_byte(input logic [7:0] b, input logic stop, output int start_cyc);
    @(negedge sysclk);
    UART_IN   = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      UART_IN = b[i];
      repeat (CPB) @(negedge sysclk);
    end
    UART_IN = stop;
    repeat (CPB) @(negedge sysclk);
    UART_IN = 1'b1;
    $display("tb->dut byte %02h stop=%0b", b, stop);
  endtask

  task automatic wait_frame(output logic [7:0] res, output int fall);
    int budget = 3000;
    while (frames.size() <= frame_idx && budget > 0) begin
      @(negedge sysclk);
      budget--;
    end
    check_val("frame_count", frames.size(), frame_idx + 1);
    res  = 8'h00;
    fall = 0;
    if (frames.size() > frame_idx) begin
      res  = frames[frame_idx];
      fall = falls[frame_idx];
      check_val("frame_start_stop", oks[frame_idx], 1);
      frame_idx++;
    end
    $display("dut->tb byte %02h at cycle %0d", res, fall);
  endtask

  // Sends A then B back to back; lat is cycles from B's start bit to TX start.
  task automatic run_pair(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] res, output int lat);
    int sa, sb, fall;
    send_byte(a, 1'b1, sa);
    send_byte(b, 1'b1, sb);
    wait_frame(res, fall);
    lat = fall - sb;
    repeat (2 * CPB) @(negedge sysclk);
  endtask

  task automatic check_digits(input string tag, input logic [6:0] d1, input logic [6:0] d2,
                              input logic [6:0] d3, input logic [6:0] d4);
    check_val({tag, "_digi1"}, digi_out1, d1);
    check_val({tag, "_digi2"}, digi_out2, d2);
    check_val({tag, "_digi3"}, digi_out3, d3);
    check_val({tag, "_digi4"}, digi_out4, d4);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] res;
    int lat_nom, lat_z1, lat_z0, lat_fe, lat_rst;
    int s0;

    Reset_n = 1'b1;
    UART_IN = 1'b1;
    switch  = 8'h00;

    // Reset state
    repeat (3) @(negedge sysclk);
    check_val("rst_uart_out", UART_OUT, 1);
    check_val("rst_led_sw0", led, 8'h00);
    check_digits("rst", SEG_0, SEG_0, SEG_0, SEG_0);
    switch = 8'h01;
    @(negedge sysclk);
    check_val("rst_led_sw1", led, 8'h00);
    switch  = 8'h00;
    Reset_n = 1'b0;
    mon_en  = 1'b1;
    repeat (4) @(negedge sysclk);

    // Nominal GCD(12, 8) = 4
    run_pair(8'h0C, 8'h08, res, lat_nom);
    check_val("nom_tx", res, 8'h04);
    check_val("nom_led", led, 8'h04);
    check_digits("nom", SEG_4, SEG_0, SEG_8, SEG_0);
    switch = 8'h01;
    @(negedge sysclk);
    check_val("nom_led_opA", led, 8'h0C);
    switch = 8'h00;
    @(negedge sysclk);

    // Zero operands
    run_pair(8'h00, 8'h2D, res, lat_z1);
    check_val("z1_tx", res, 8'h2D);
    check_val("z1_led", led, 8'h2D);
    check_val("z1_digi1", digi_out1, SEG_D);
    check_val("z1_digi2", digi_out2, SEG_2);
    switch = 8'h01;
    @(negedge sysclk);
    check_val("z1_led_opA", led, 8'h00);
    switch = 8'h00;
    @(negedge sysclk);

    run_pair(8'h00, 8'h00, res, lat_z0);
    check_val("z0_tx", res, 8'h00);
    check_val("z0_led", led, 8'h00);

    // Framing error: bad byte is dropped, then GCD(6, 9) = 3
    send_byte(8'h55, 1'b0, s0);
    repeat (2 * CPB) @(negedge sysclk);
    run_pair(8'h06, 8'h09, res, lat_fe);
    check_val("fe_tx", res, 8'h03);
    check_val("fe_led", led, 8'h03);
    check_digits("fe", SEG_3, SEG_0, SEG_9, SEG_0);

    // Reset during B's data bits
    send_byte(8'h20, 1'b1, s0);
    @(negedge sysclk);
    UART_IN = 1'b0;
    repeat (CPB) @(negedge sysclk);
    for (int i = 0; i < 3; i++) begin
      UART_IN = (i == 0);
      repeat (CPB) @(negedge sysclk);
    end
    repeat (CPB / 2) @(negedge sysclk);
    Reset_n = 1'b1;
    UART_IN = 1'b1;
    repeat (2) @(negedge sysclk);
    Reset_n = 1'b0;
    @(negedge sysclk);
    check_val("mrst_uart_out", UART_OUT, 1);
    check_val("mrst_led", led, 8'h00);
    check_digits("mrst", SEG_0, SEG_0, SEG_0, SEG_0);
    repeat (2 * CPB) @(negedge sysclk);
    check_val("mrst_no_frame", frames.size(), frame_idx);
    run_pair(8'hFF, 8'h11, res, lat_rst);
    check_val("mrst_tx", res, 8'h11);
    check_val("mrst_led_after", led, 8'h11);
    check_digits("mrst_after", SEG_1, SEG_1, SEG_1, SEG_1);

    // CALC duration relative to the single-cycle (x==0) case:
    // (12,8): 3 cycles, (0,0): 1, (6,9): 3, (255,17): 15.
    check_val("calc_len_12_8", lat_nom - lat_z1, 2);
    check_val("calc_len_0_0", lat_z0 - lat_z1, 0);
    check_val("calc_len_6_9", lat_fe - lat_z1, 2);
    check_val("calc_len_255_17", lat_rst - lat_z1, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
